// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS control unit: opcodes, datapath
// select codes, ALU operation codes and the controller state encoding.
package mc_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_BGTZ  = 6'b000111;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  typedef enum logic [2:0] {
    ALU_ADD   = 3'b000,
    ALU_SUB   = 3'b001,
    ALU_FUNCT = 3'b010,
    ALU_AND   = 3'b100,
    ALU_OR    = 3'b101,
    ALU_GTZ   = 3'b110,
    ALU_SLT   = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    SRCB_B      = 2'b00,
    SRCB_FOUR   = 2'b01,
    SRCB_IMM    = 2'b10,
    SRCB_IMM_SH = 2'b11
  } src_b_e;

  typedef enum logic [1:0] {
    PCSRC_ALU    = 2'b00,
    PCSRC_ALUOUT = 2'b01,
    PCSRC_JUMP   = 2'b10
  } pc_src_e;

  typedef enum logic [1:0] {
    BR_EQ  = 2'b00,
    BR_NE  = 2'b01,
    BR_GTZ = 2'b10
  } branch_e;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_MEM_ADDR,
    S_MEM_READ,
    S_MEM_WB,
    S_MEM_WRITE,
    S_EXEC_R,
    S_ALU_WB,
    S_EXEC_I,
    S_IMM_WB,
    S_BRANCH,
    S_JUMP
  } state_e;

  // ALU operation for the immediate-arithmetic group; addi is the fallback.
  function automatic alu_op_e imm_alu_op(input logic [5:0] op);
    case (op)
      OP_ANDI: return ALU_AND;
      OP_ORI:  return ALU_OR;
      OP_SLTI: return ALU_SLT;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive not-ready cycles of a memory access and flags the cycle in
// which the count would reach MEM_TIMEOUT.
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 16,
  parameter int TMR_W       = 5
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  logic [TMR_W-1:0] count;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its inputs from the same pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc) begin
      count <= count + 1'b1;
    end
  end

  // This cycle is the MEM_TIMEOUT-th consecutive wait.
  assign expired = inc && (count == TMR_W'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/unidad_control_multiciclo.sv
// Multi-cycle MIPS control FSM sequencing ALU, memory port, IR, PC and register file.
// Optional JUMP_EN macro adds the j instruction (opcode 000010) via a JUMP state.
module unidad_control_multiciclo
  import mc_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int TMR_W       = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
  input  logic [5:0] OpCode,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       MemToReg,
  output logic       IRWrite,
  output logic       ALUSrcA,
  output logic       RegWrite,
  output logic       RegDst,
  output logic [1:0] PCSource,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUOp,
  output logic [1:0] BranchType,
  output logic       instr_done,
  output logic       illegal_op,
  output logic       mem_err
);

  state_e state, next_state;
  state_e done_next;
  logic   waiting, tmr_inc, tmr_clr, tmr_expired;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= next_state;
  end

  assign waiting   = (state == S_FETCH) || (state == S_MEM_READ) || (state == S_MEM_WRITE);
  assign tmr_inc   = waiting && !mem_ready;
  assign tmr_clr   = !tmr_inc || (next_state != state);
  assign done_next = run ? S_FETCH : S_IDLE;

  mem_wait_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT),
    .TMR_W      (TMR_W)
  ) u_mem_wait_timer (
    .clk    (clk),
    .reset  (reset),
    .clr    (tmr_clr),
    .inc    (tmr_inc),
    .expired(tmr_expired)
  );

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    next_state  = state;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    MemToReg    = 1'b0;
    IRWrite     = 1'b0;
    ALUSrcA     = 1'b0;
    RegWrite    = 1'b0;
    RegDst      = 1'b0;
    PCSource    = PCSRC_ALU;
    ALUSrcB     = SRCB_B;
    ALUOp       = ALU_ADD;
    BranchType  = BR_EQ;
    instr_done  = 1'b0;
    illegal_op  = 1'b0;
    mem_err     = 1'b0;

    unique case (state)
      S_IDLE: begin
        if (run) next_state = S_FETCH;
      end

      S_FETCH: begin
        MemRead = !tmr_expired;
        ALUSrcB = SRCB_FOUR;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
        if (mem_ready) begin
          next_state = S_DECODE;
        end else if (tmr_expired) begin
          mem_err    = 1'b1;
          next_state = S_IDLE;
        end
      end

      S_DECODE: begin
        ALUSrcB = SRCB_IMM_SH;
        case (OpCode)
          OP_LW, OP_SW:                     next_state = S_MEM_ADDR;
          OP_RTYPE:                         next_state = S_EXEC_R;
          OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: next_state = S_EXEC_I;
          OP_BEQ, OP_BNE, OP_BGTZ:          next_state = S_BRANCH;
`ifdef JUMP_EN
          OP_J:                             next_state = S_JUMP;
`else
          OP_J: begin
            illegal_op = 1'b1;
            next_state = done_next;
          end
`endif
          default: begin
            illegal_op = 1'b1;
            next_state = done_next;
          end
        endcase
      end

      S_MEM_ADDR: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = SRCB_IMM;
        next_state = (OpCode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
      end

      S_MEM_READ: begin
        MemRead = !tmr_expired;
        IorD    = 1'b1;
        if (mem_ready) begin
          next_state = S_MEM_WB;
        end else if (tmr_expired) begin
          mem_err    = 1'b1;
          next_state = S_IDLE;
        end
      end

      S_MEM_WB: begin
        RegWrite   = 1'b1;
        MemToReg   = 1'b1;
        instr_done = 1'b1;
        next_state = done_next;
      end

      S_MEM_WRITE: begin
        MemWrite = !tmr_expired;
        IorD     = 1'b1;
        if (mem_ready) begin
          instr_done = 1'b1;
          next_state = done_next;
        end else if (tmr_expired) begin
          mem_err    = 1'b1;
          next_state = S_IDLE;
        end
      end

      S_EXEC_R: begin
        ALUSrcA    = 1'b1;
        ALUOp      = ALU_FUNCT;
        next_state = S_ALU_WB;
      end

      S_ALU_WB: begin
        RegWrite   = 1'b1;
        RegDst     = 1'b1;
        instr_done = 1'b1;
        next_state = done_next;
      end

      S_EXEC_I: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = SRCB_IMM;
        ALUOp      = imm_alu_op(OpCode);
        next_state = S_IMM_WB;
      end

      S_IMM_WB: begin
        RegWrite   = 1'b1;
        instr_done = 1'b1;
        next_state = done_next;
      end

      S_BRANCH: begin
        ALUSrcA     = 1'b1;
        PCWriteCond = 1'b1;
        PCSource    = PCSRC_ALUOUT;
        ALUOp       = (OpCode == OP_BGTZ) ? ALU_GTZ : ALU_SUB;
        BranchType  = (OpCode == OP_BGTZ) ? BR_GTZ :
                      (OpCode == OP_BNE)  ? BR_NE  : BR_EQ;
        instr_done  = 1'b1;
        next_state  = done_next;
      end

`ifdef JUMP_EN
      S_JUMP: begin
        PCWrite    = 1'b1;
        PCSource   = PCSRC_JUMP;
        instr_done = 1'b1;
        next_state = done_next;
      end
`endif

      default: next_state = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_unidad_control_multiciclo.sv
// Directed bench for unidad_control_multiciclo: per-cycle expected control words
// are queued as stimulus is applied and compared on the falling edge.
module tb_unidad_control_multiciclo;

  typedef struct packed {
    logic       pc_write, pc_write_cond, iord, mem_read, mem_write;
    logic       mem_to_reg, ir_write, alu_src_a, reg_write, reg_dst;
    logic [1:0] pc_source;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic [1:0] branch_type;
    logic       instr_done, illegal_op, mem_err;
  } ctl_t;

  typedef struct {
    string tag;
    ctl_t  v;
  } sb_item_t;

  localparam logic [5:0] OP_R = 6'b000000, OP_J = 6'b000010, OP_BEQ = 6'b000100,
                         OP_BNE = 6'b000101, OP_BGTZ = 6'b000111, OP_LW = 6'b100011,
                         OP_SW = 6'b101011;

  logic       clk = 1'b0;
  logic       reset, run, mem_ready;
  logic [5:0] OpCode;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemToReg, IRWrite;
  logic       ALUSrcA, RegWrite, RegDst, instr_done, illegal_op, mem_err;
  logic [1:0] PCSource, ALUSrcB, BranchType;
  logic [2:0] ALUOp;
  ctl_t       obs;

  sb_item_t   sb_q[$];
  int         compared   = 0;
  int         mismatched = 0;

  always #5 clk = ~clk;

  unidad_control_multiciclo #(.MEM_TIMEOUT(16), .TMR_W(5)) dut (
    .clk(clk), .reset(reset), .run(run), .OpCode(OpCode), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .MemToReg(MemToReg), .IRWrite(IRWrite), .ALUSrcA(ALUSrcA),
    .RegWrite(RegWrite), .RegDst(RegDst), .PCSource(PCSource), .ALUSrcB(ALUSrcB),
    .ALUOp(ALUOp), .BranchType(BranchType), .instr_done(instr_done),
    .illegal_op(illegal_op), .mem_err(mem_err)
  );

  assign obs = '{pc_write: PCWrite, pc_write_cond: PCWriteCond, iord: IorD,
                 mem_read: MemRead, mem_write: MemWrite, mem_to_reg: MemToReg,
                 ir_write: IRWrite, alu_src_a: ALUSrcA, reg_write: RegWrite,
                 reg_dst: RegDst, pc_source: PCSource, alu_src_b: ALUSrcB,
                 alu_op: ALUOp, branch_type: BranchType, instr_done: instr_done,
                 illegal_op: illegal_op, mem_err: mem_err};

  // Expected control words, written from the per-state output table.
  function automatic ctl_t c_zero();
    ctl_t c = '0;
    return c;
  endfunction
  function automatic ctl_t c_fetch(input logic rdy);
    ctl_t c = '0;
    c.mem_read = 1'b1; c.alu_src_b = 2'b01; c.ir_write = rdy; c.pc_write = rdy;
    return c;
  endfunction
  function automatic ctl_t c_fetch_timeout();
    ctl_t c = '0;
    c.alu_src_b = 2'b01; c.mem_err = 1'b1;
    return c;
  endfunction
  function automatic ctl_t c_decode(input logic illegal);
    ctl_t c = '0;
    c.alu_src_b = 2'b11; c.illegal_op = illegal;
    return c;
  endfunction
  function automatic ctl_t c_mem_addr();
    ctl_t c = '0;
    c.alu_src_a = 1'b1; c.alu_src_b = 2'b10;
    return c;
  endfunction
  function automatic ctl_t c_mem_read();
    ctl_t c = '0;
    c.mem_read = 1'b1; c.iord = 1'b1;
    return c;
  endfunction
  function automatic ctl_t c_mem_wb();
    ctl_t c = '0;
    c.reg_write = 1'b1; c.mem_to_reg = 1'b1; c.instr_done = 1'b1;
    return c;
  endfunction
  function automatic ctl_t c_mem_write(input logic rdy, input logic timeout);
    ctl_t c = '0;
    c.mem_write = !timeout; c.iord = 1'b1; c.instr_done = rdy; c.mem_err = timeout;
    return c;
  endfunction
  function automatic ctl_t c_exec_r();
    ctl_t c = '0;
    c.alu_src_a = 1'b1; c.alu_op = 3'b010;
    return c;
  endfunction
  function automatic ctl_t c_alu_wb();
    ctl_t c = '0;
    c.reg_write = 1'b1; c.reg_dst = 1'b1; c.instr_done = 1'b1;
    return c;
  endfunction
  function automatic ctl_t c_exec_i(input logic [2:0] op);
    ctl_t c = '0;
    c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; c.alu_op = op;
    return c;
  endfunction
  function automatic ctl_t c_imm_wb();
    ctl_t c = '0;
    c.reg_write = 1'b1; c.instr_done = 1'b1;
    return c;
  endfunction
  function automatic ctl_t c_branch(input logic [2:0] op, input logic [1:0] bt);
    ctl_t c = '0;
    c.alu_src_a = 1'b1; c.alu_op = op; c.pc_write_cond = 1'b1;
    c.pc_source = 2'b01; c.branch_type = bt; c.instr_done = 1'b1;
    return c;
  endfunction
  function automatic ctl_t c_jump();
    ctl_t c = '0;
    c.pc_write = 1'b1; c.pc_source = 2'b10; c.instr_done = 1'b1;
    return c;
  endfunction

  // One clock cycle: queue the expectation, compare on the falling edge,
  // then leave the caller just after the next rising edge to drive inputs.
  task automatic cyc(input string tag, input ctl_t exp_v);
    sb_item_t it;
    sb_q.push_back('{tag: tag, v: exp_v});
    @(negedge clk);
    it = sb_q.pop_front();
    compared++;
    assert (obs === it.v) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", it.tag, obs, it.v);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [5:0] imm_ops [4];
    logic [2:0] imm_alu [4];
    imm_ops = '{6'b001000, 6'b001100, 6'b001101, 6'b001010};
    imm_alu = '{3'b000, 3'b100, 3'b101, 3'b111};

    reset = 1'b1; run = 1'b1; mem_ready = 1'b1; OpCode = OP_R;
    cyc("reset_hold", c_zero());
    reset = 1'b0;
    cyc("idle_after_reset", c_zero());

    // R-type, 4 cycles
    cyc("r_fetch", c_fetch(1'b1));
    cyc("r_decode", c_decode(1'b0));
    cyc("r_exec", c_exec_r());
    cyc("r_wb", c_alu_wb());

    // lw with three not-ready cycles in MEM_READ
    OpCode = OP_LW;
    cyc("lw_fetch", c_fetch(1'b1));
    cyc("lw_decode", c_decode(1'b0));
    cyc("lw_addr", c_mem_addr());
    mem_ready = 1'b0;
    repeat (3) cyc("lw_read_wait", c_mem_read());
    mem_ready = 1'b1;
    cyc("lw_read_rdy", c_mem_read());
    cyc("lw_wb", c_mem_wb());

    // branches, 3 cycles each
    OpCode = OP_BGTZ;
    cyc("bgtz_fetch", c_fetch(1'b1));
    cyc("bgtz_decode", c_decode(1'b0));
    cyc("bgtz_branch", c_branch(3'b110, 2'b10));
    OpCode = OP_BEQ;
    cyc("beq_fetch", c_fetch(1'b1));
    cyc("beq_decode", c_decode(1'b0));
    cyc("beq_branch", c_branch(3'b001, 2'b00));
    OpCode = OP_BNE;
    cyc("bne_fetch", c_fetch(1'b1));
    cyc("bne_decode", c_decode(1'b0));
    cyc("bne_branch", c_branch(3'b001, 2'b01));

    // sw, one not-ready cycle
    OpCode = OP_SW;
    cyc("sw_fetch", c_fetch(1'b1));
    cyc("sw_decode", c_decode(1'b0));
    cyc("sw_addr", c_mem_addr());
    mem_ready = 1'b0;
    cyc("sw_write_wait", c_mem_write(1'b0, 1'b0));
    mem_ready = 1'b1;
    cyc("sw_write_rdy", c_mem_write(1'b1, 1'b0));

    // immediate arithmetic group
    for (int i = 0; i < 4; i++) begin
      OpCode = imm_ops[i];
      cyc("imm_fetch", c_fetch(1'b1));
      cyc("imm_decode", c_decode(1'b0));
      cyc("imm_exec", c_exec_i(imm_alu[i]));
      cyc("imm_wb", c_imm_wb());
    end

    // fetch stalled two cycles: no PC/IR write until ready
    OpCode = OP_R; mem_ready = 1'b0;
    repeat (2) cyc("fetch_stall", c_fetch(1'b0));
    mem_ready = 1'b1;
    cyc("fetch_stall_rdy", c_fetch(1'b1));
    cyc("fetch_stall_decode", c_decode(1'b0));
    cyc("fetch_stall_exec", c_exec_r());
    cyc("fetch_stall_wb", c_alu_wb());

    // j opcode
    OpCode = OP_J;
    cyc("j_fetch", c_fetch(1'b1));
`ifdef JUMP_EN
    cyc("j_decode", c_decode(1'b0));
    cyc("j_jump", c_jump());
`else
    cyc("j_illegal", c_decode(1'b1));
`endif
    // next instruction must start in FETCH right away
    OpCode = 6'b111111;
    cyc("after_j_fetch", c_fetch(1'b1));
    run = 1'b0;
    cyc("illegal_decode", c_decode(1'b1));
    cyc("illegal_idle", c_zero());
    cyc("illegal_idle_hold", c_zero());
    run = 1'b1;
    cyc("idle_leave", c_zero());

    // run dropped mid-instruction: instruction completes, then IDLE
    OpCode = OP_R;
    cyc("rundrop_fetch", c_fetch(1'b1));
    run = 1'b0;
    cyc("rundrop_decode", c_decode(1'b0));
    cyc("rundrop_exec", c_exec_r());
    cyc("rundrop_wb", c_alu_wb());
    cyc("rundrop_idle", c_zero());
    run = 1'b1;
    cyc("rundrop_idle_leave", c_zero());

    // asynchronous reset in the middle of MEM_READ
    OpCode = OP_LW;
    cyc("rstmid_fetch", c_fetch(1'b1));
    cyc("rstmid_decode", c_decode(1'b0));
    cyc("rstmid_addr", c_mem_addr());
    mem_ready = 1'b0;
    cyc("rstmid_read", c_mem_read());
    reset = 1'b1;
    cyc("rstmid_reset", c_zero());
    reset = 1'b0; mem_ready = 1'b1;
    cyc("rstmid_idle", c_zero());
    cyc("rstmid_refetch", c_fetch(1'b1));
    cyc("rstmid_redecode", c_decode(1'b0));
    cyc("rstmid_readdr", c_mem_addr());
    cyc("rstmid_reread", c_mem_read());
    cyc("rstmid_wb", c_mem_wb());

    // ready on the would-be timeout cycle wins
    cyc("edge_fetch", c_fetch(1'b1));
    cyc("edge_decode", c_decode(1'b0));
    cyc("edge_addr", c_mem_addr());
    mem_ready = 1'b0;
    repeat (15) cyc("edge_read_wait", c_mem_read());
    mem_ready = 1'b1;
    cyc("edge_read_rdy16", c_mem_read());
    cyc("edge_wb", c_mem_wb());

    // fetch timeout after 16 not-ready cycles
    OpCode = OP_R; mem_ready = 1'b0;
    repeat (15) cyc("to_fetch_wait", c_fetch(1'b0));
    cyc("to_fetch_err", c_fetch_timeout());
    cyc("to_fetch_idle", c_zero());
    mem_ready = 1'b1;
    cyc("to_refetch", c_fetch(1'b1));
    cyc("to_decode", c_decode(1'b0));
    cyc("to_exec", c_exec_r());
    cyc("to_wb", c_alu_wb());

    // MEM_WRITE timeout
    OpCode = OP_SW;
    cyc("tow_fetch", c_fetch(1'b1));
    cyc("tow_decode", c_decode(1'b0));
    cyc("tow_addr", c_mem_addr());
    mem_ready = 1'b0;
    repeat (15) cyc("tow_wait", c_mem_write(1'b0, 1'b0));
    run = 1'b0;
    cyc("tow_err", c_mem_write(1'b0, 1'b1));
    cyc("tow_idle", c_zero());

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
